adc_sample_readout: RTL and testbench

- Read side of the ADC sample path. Accepts 14-bit samples pushed by the ADC controller (one-cycle valid strobe, no backpressure) and buffers them in a DEPTH-entry FIFO.
- Delivers samples to the downstream host/data-packer interface through a valid/ready stream with per-line last markers.
- Reports occupancy and overflow (sticky flag plus drop count).
- Sits between the ADC controller output and the readout/packetiser logic.

---
 rtl/adc_sample_readout_pkg.sv | 22 ++
 rtl/adc_sample_readout_if.sv | 19 +
 rtl/adc_sample_readout_ram.sv | 33 +++
 rtl/adc_sample_readout.sv | 199 +++++++++++++++++++
 tb/tb_adc_sample_readout.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sample_readout_pkg.sv
// Shared definitions for the ADC sample readout path.
// Holds the default geometry of the sample buffer, the output-stage state
// encoding, the drop counter width and a saturating increment helper.
package adc_readout_pkg;

  localparam int ADC_DATA_WIDTH = 14;
  localparam int ADC_DEPTH      = 2048;
  localparam int ADC_ADDR_WIDTH = 11;
  localparam int DROP_W         = 16;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FETCH = 2'd1,
    OUT_VALID = 2'd2
  } out_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/adc_sample_readout_if.sv
// Read-side sample stream of the ADC readout buffer.
//   rd_valid : a sample is presented on rd_data
//   rd_data  : sample value
//   rd_last  : sample closes a line
//   rd_ready : consumer accepts the presented sample
// master = buffer (source), slave = packer/host (sink).
interface adc_sample_readout_if
  import adc_readout_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH
);
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_ready;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/adc_sample_readout_ram.sv
// Simple dual-port sample array: one synchronous write port, one synchronous
// registered read port (1-cycle latency). Contents are not reset so the
// array maps onto block RAM.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe, rd_data_o updates on the following edge
//   rd_addr_i : read address
//   rd_data_o : registered read data, holds when rd_en_i is low
module sample_ram_1r1w
  import adc_readout_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int ADDR_WIDTH = ADC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/adc_sample_readout.sv
// ADC sample readout buffer.
// Samples strobed in by the ADC controller are stored in a DEPTH-entry buffer
// (array plus one output register) and delivered on a valid/ready stream with
// per-line last markers. Reports occupancy and overflow (sticky + drop count).
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_valid     : one-cycle sample strobe (no backpressure)
//   wr_data      : sample value
//   flush        : synchronous clear of buffered contents
//   line_len     : samples per line, 0 disables rd_last
//   rd           : output stream (rd_valid/rd_data/rd_last/rd_ready)
//   level        : samples held, 0..DEPTH
//   full, empty  : level == DEPTH / level == 0
//   overflow     : sticky, a sample was dropped
//   overflow_clr : clears overflow and drop_count
//   drop_count   : saturating count of dropped samples
module adc_sample_readout
  import adc_readout_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int DEPTH      = ADC_DEPTH,
  parameter int ADDR_WIDTH = ADC_ADDR_WIDTH,
  parameter int LINE_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  input  logic [LINE_W-1:0]     line_len,
  adc_sample_readout_if.master  rd,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int CW = ADDR_WIDTH + 1;

  out_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         arr_cnt_q, arr_cnt_d;
  logic [CW-1:0]         level_q, level_d;
  logic                  full_q, empty_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]     line_len_q, line_len_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic rd_valid_w;
  logic push, drop, pop, rd_issue, last_hit;

  assign rd_valid_w = (state_q == OUT_VALID);

  // full is taken from the registered state, so a pop in the same cycle does
  // not make room for a write that arrives while full.
  assign push = wr_valid && !full_q && !flush;
  assign drop = wr_valid &&  full_q && !flush;
  assign pop  = rd_valid_w && rd.rd_ready && !flush;

  assign last_hit = (line_len_q != '0) && (line_cnt_q == line_len_q - LINE_W'(1));

  sample_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  // Output stage: EMPTY issues a read, FETCH captures the array output,
  // VALID presents it until popped.
  always_comb begin
    state_d   = state_q;
    rd_issue  = 1'b0;
    rd_data_d = rd_data_q;
    unique case (state_q)
      OUT_EMPTY: begin
        if (arr_cnt_q != '0) begin
          rd_issue = 1'b1;
          state_d  = OUT_FETCH;
        end
      end
      OUT_FETCH: begin
        rd_data_d = ram_rdata;
        state_d   = OUT_VALID;
      end
      OUT_VALID: begin
        if (pop) begin
          if (arr_cnt_q != '0) begin
            rd_issue = 1'b1;
            state_d  = OUT_FETCH;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (flush) begin
      state_d  = OUT_EMPTY;
      rd_issue = 1'b0;
    end
  end

  // Pointers, occupancy, line tracking and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    arr_cnt_d  = arr_cnt_q;
    level_d    = level_q;
    line_cnt_d = line_cnt_q;
    line_len_d = line_len_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      arr_cnt_d  = '0;
      level_d    = '0;
      line_cnt_d = '0;
    end else begin
      if (push)     wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      arr_cnt_d = arr_cnt_q + CW'(push) - CW'(rd_issue);
      level_d   = level_q + CW'(push) - CW'(pop);
      if (pop) begin
        if (line_len_q == '0 || last_hit) line_cnt_d = '0;
        else                              line_cnt_d = line_cnt_q + LINE_W'(1);
      end
    end

    // Line length is sampled only at a line boundary and never while a sample
    // is being presented, so rd_last cannot change under a stalled consumer.
    if (line_cnt_q == '0 && !rd_valid_w) line_len_d = line_len;

    // A drop in the clearing cycle is applied after the clear.
    if (overflow_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc(drop_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OUT_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      arr_cnt_q  <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      line_cnt_q <= '0;
      line_len_q <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      arr_cnt_q  <= arr_cnt_d;
      level_q    <= level_d;
      full_q     <= (level_d == CW'(DEPTH));
      empty_q    <= (level_d == '0);
      rd_data_q  <= rd_data_d;
      line_cnt_q <= line_cnt_d;
      line_len_q <= line_len_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign rd.rd_valid = rd_valid_w;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_last  = rd_valid_w && last_hit;

  assign level      = level_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_adc_sample_readout.sv
// Testbench for adc_sample_readout: table-driven vectors for basic push/pop
// timing plus directed sequences for line markers, full/overflow, flush and
// asynchronous reset.
module tb_adc_sample_readout;
  import adc_readout_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [13:0] wr_data;
  logic        flush;
  logic [11:0] line_len;
  logic [11:0] level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] drop_count;

  adc_sample_readout_if #(.DATA_WIDTH(14)) rd_if ();

  adc_sample_readout #(
    .DATA_WIDTH (14),
    .DEPTH      (2048),
    .ADDR_WIDTH (11),
    .LINE_W     (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .flush        (flush),
    .line_len     (line_len),
    .rd           (rd_if),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        wv;
    logic [13:0] wd;
    logic        rr;
    logic        exp_rv;
    logic [13:0] exp_rd;
    logic [11:0] exp_lvl;
  } vec_t;

  vec_t vecs [17];

  int got, nexp, bad, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one edge; inputs driven after this are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"},   32'(rd_if.rd_valid), 32'(0));
    chk({tag, "_rd_data"},    32'(rd_if.rd_data),  32'(0));
    chk({tag, "_rd_last"},    32'(rd_if.rd_last),  32'(0));
    chk({tag, "_level"},      32'(level),          32'(0));
    chk({tag, "_full"},       32'(full),           32'(0));
    chk({tag, "_empty"},      32'(empty),          32'(1));
    chk({tag, "_overflow"},   32'(overflow),       32'(0));
    chk({tag, "_drop_count"}, 32'(drop_count),     32'(0));
  endtask

  initial begin
    // wv, wd, rr, exp_rv, exp_rd, exp_lvl
    vecs[0]  = '{1'b1, 14'h1234, 1'b1, 1'b0, 14'h0000, 12'd1};
    vecs[1]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd1};
    vecs[2]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h1234, 12'd1};
    vecs[3]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd0};
    vecs[4]  = '{1'b1, 14'h0AAA, 1'b1, 1'b0, 14'h0000, 12'd1};
    vecs[5]  = '{1'b1, 14'h1555, 1'b1, 1'b0, 14'h0000, 12'd2};
    vecs[6]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0AAA, 12'd2};
    vecs[7]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd1};
    vecs[8]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h1555, 12'd1};
    vecs[9]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd0};
    vecs[10] = '{1'b1, 14'h3FFF, 1'b0, 1'b0, 14'h0000, 12'd1};
    vecs[11] = '{1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 12'd1};
    vecs[12] = '{1'b0, 14'h0000, 1'b0, 1'b1, 14'h3FFF, 12'd1};
    vecs[13] = '{1'b1, 14'h0001, 1'b0, 1'b1, 14'h3FFF, 12'd2};
    vecs[14] = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd1};
    vecs[15] = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0001, 12'd1};
    vecs[16] = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 12'd0};

    rst_n          = 1'b0;
    wr_valid       = 1'b0;
    wr_data        = '0;
    flush          = 1'b0;
    line_len       = '0;
    overflow_clr   = 1'b0;
    rd_if.rd_ready = 1'b0;

    // Reset state
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(); step();

    // Table: single/back-to-back transfers and a stalled consumer
    for (int i = 0; i < 17; i++) begin
      wr_valid       = vecs[i].wv;
      wr_data        = vecs[i].wd;
      rd_if.rd_ready = vecs[i].rr;
      step();
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_if.rd_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_level", i),    32'(level),          32'(vecs[i].exp_lvl));
      chk($sformatf("vec%0d_empty", i),    32'(empty),          32'(vecs[i].exp_lvl == 12'd0));
      chk($sformatf("vec%0d_rd_last", i),  32'(rd_if.rd_last),  32'(0));
      if (vecs[i].exp_rv)
        chk($sformatf("vec%0d_rd_data", i), 32'(rd_if.rd_data), 32'(vecs[i].exp_rd));
    end
    wr_valid = 1'b0;

    // Line markers: line_len=4, samples 0..11 -> last on 3, 7, 11
    line_len       = 12'd4;
    rd_if.rd_ready = 1'b1;
    step();
    for (int s = 0; s < 12; s++) begin
      wr_valid = 1'b1;
      wr_data  = 14'(s);
      step();
      wr_valid = 1'b0;
      got = 0;
      for (int w = 0; w < 6 && got == 0; w++) begin
        step();
        if (rd_if.rd_valid) got = 1;
      end
      chk($sformatf("line_s%0d_arrived", s), 32'(got), 32'(1));
      chk($sformatf("line_s%0d_data", s),    32'(rd_if.rd_data), 32'(s));
      chk($sformatf("line_s%0d_last", s),    32'(rd_if.rd_last), 32'((s % 4) == 3));
      step();
    end

    // Fill to full with consumer stalled, then overflow
    line_len       = 12'd0;
    rd_if.rd_ready = 1'b0;
    step();
    for (int i = 0; i < 2048; i++) begin
      wr_valid = 1'b1;
      wr_data  = 14'(i);
      step();
    end
    wr_valid = 1'b0;
    chk("fill_level",    32'(level),    32'(2048));
    chk("fill_full",     32'(full),     32'(1));
    chk("fill_overflow", 32'(overflow), 32'(0));
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 14'h3ABC;
      step();
    end
    wr_valid = 1'b0;
    chk("ovf_level",      32'(level),          32'(2048));
    chk("ovf_full",       32'(full),           32'(1));
    chk("ovf_flag",       32'(overflow),       32'(1));
    chk("ovf_drop_count", 32'(drop_count),     32'(3));
    chk("ovf_head_valid", 32'(rd_if.rd_valid), 32'(1));
    chk("ovf_head_data",  32'(rd_if.rd_data),  32'(0));

    // overflow_clr together with a drop: the drop wins
    wr_valid     = 1'b1;
    overflow_clr = 1'b1;
    step();
    wr_valid     = 1'b0;
    overflow_clr = 1'b0;
    chk("clrdrop_overflow",   32'(overflow),   32'(1));
    chk("clrdrop_drop_count", 32'(drop_count), 32'(1));

    // Push and pop in the same cycle while full: write dropped
    wr_valid       = 1'b1;
    rd_if.rd_ready = 1'b1;
    step();
    wr_valid       = 1'b0;
    rd_if.rd_ready = 1'b0;
    chk("fullpp_level",      32'(level),      32'(2047));
    chk("fullpp_full",       32'(full),       32'(0));
    chk("fullpp_drop_count", 32'(drop_count), 32'(2));

    // Drain: remaining samples 1..2047 in order
    rd_if.rd_ready = 1'b1;
    nexp = 1;
    bad  = 0;
    cyc  = 0;
    while (nexp < 2048 && cyc < 6000) begin
      step();
      cyc++;
      if (rd_if.rd_valid) begin
        if (rd_if.rd_data !== 14'(nexp)) bad++;
        nexp++;
      end
    end
    step();
    chk("drain_count",      32'(nexp),           32'(2048));
    chk("drain_order_errs", 32'(bad),            32'(0));
    chk("drain_level",      32'(level),          32'(0));
    chk("drain_empty",      32'(empty),          32'(1));
    chk("drain_rd_valid",   32'(rd_if.rd_valid), 32'(0));

    // Flush with a simultaneous write and pop
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 14'(14'h100 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("preflush_level", 32'(level), 32'(5));
    flush          = 1'b1;
    wr_valid       = 1'b1;
    wr_data        = 14'h2AAA;
    rd_if.rd_ready = 1'b1;
    step();
    flush          = 1'b0;
    wr_valid       = 1'b0;
    rd_if.rd_ready = 1'b0;
    chk("flush_level",      32'(level),          32'(0));
    chk("flush_empty",      32'(empty),          32'(1));
    chk("flush_rd_valid",   32'(rd_if.rd_valid), 32'(0));
    chk("flush_overflow",   32'(overflow),       32'(1));
    chk("flush_drop_count", 32'(drop_count),     32'(2));
    step(); step();
    chk("flush_settled_valid", 32'(rd_if.rd_valid), 32'(0));
    rd_if.rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 14'h0777;
    step();
    wr_valid = 1'b0;
    step(); step();
    chk("postflush_valid", 32'(rd_if.rd_valid), 32'(1));
    chk("postflush_data",  32'(rd_if.rd_data),  32'(14'h0777));
    step();
    chk("postflush_level", 32'(level), 32'(0));

    // overflow_clr alone
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("clr_overflow",   32'(overflow),   32'(0));
    chk("clr_drop_count", 32'(drop_count), 32'(0));

    // Asynchronous reset mid-stream
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 14'(14'h1111 * (i + 1));
      step();
    end
    wr_valid = 1'b0;
    step();
    chk("prerst_valid", 32'(rd_if.rd_valid), 32'(1));
    chk("prerst_data",  32'(rd_if.rd_data),  32'(14'h1111));
    chk("prerst_level", 32'(level),          32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    step(); step();
    chk("afterrst_valid", 32'(rd_if.rd_valid), 32'(0));
    chk("afterrst_empty", 32'(empty),          32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
